// File: rtl/rsnn_param_stream_tx.sv
// Host-side transmitter for the RSNN serial parameter load: takes a byte stream,
// shifts it out MSB-first one bit per receiver acknowledge, and watches for end_writing.
module rsnn_param_stream_tx #(
    parameter int TOTAL_BITS  = 312,
    parameter int ACK_TIMEOUT = 63,
    parameter int CNT_W       = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [7:0]       i_byte_in,
    input  logic             i_byte_valid,
    output logic             o_byte_ready,
    input  logic             i_data_written,
    input  logic             i_end_writing,
    output logic             o_load_params,
    output logic             o_data_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [CNT_W-1:0] o_bits_sent
);
    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TOTAL_BITS);
    localparam logic [CNT_W-1:0]  FINAL_IDX = CNT_W'(TOTAL_BITS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_FETCH, S_SHIFT, S_WAIT_END, S_DONE, S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit_in_byte;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_bits_sent;

    logic w_final_bit;
    logic w_timeout;
    logic w_ack;
    logic w_launch;

    assign w_final_bit = (r_bits_sent == FINAL_IDX);
    assign w_timeout   = (r_wait == WAIT_LAST);
    assign w_ack       = (r_state == S_SHIFT) && i_data_written;
    assign w_launch    = ((r_state == S_IDLE) || (r_state == S_ERR)) && i_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_REQ;
            S_REQ:   w_next = i_end_writing ? S_ERR : S_FETCH;
            S_FETCH: begin
                if (i_end_writing && (r_bits_sent < LAST_CNT)) w_next = S_ERR;
                else if (i_byte_valid)                         w_next = S_SHIFT;
            end
            S_SHIFT: begin
                // end_writing together with the last ack is a clean finish, anything else early is a violation
                if (i_data_written && i_end_writing && w_final_bit) w_next = S_DONE;
                else if (i_end_writing)                             w_next = S_ERR;
                else if (i_data_written) begin
                    if (r_bit_in_byte == 3'd7) w_next = w_final_bit ? S_WAIT_END : S_FETCH;
                end
                else if (w_timeout)                                 w_next = S_ERR;
            end
            S_WAIT_END: begin
                if (i_end_writing)  w_next = S_DONE;
                else if (w_timeout) w_next = S_ERR;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   if (i_start) w_next = S_REQ;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_load_params = 1'b0;
        o_byte_ready  = 1'b0;
        o_data_out    = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        o_error       = 1'b0;
        case (r_state)
            S_REQ:      begin o_load_params = 1'b1; o_busy = 1'b1; end
            S_FETCH:    begin o_byte_ready  = 1'b1; o_busy = 1'b1; end
            S_SHIFT:    begin o_data_out = r_shift[7]; o_busy = 1'b1; end
            S_WAIT_END: o_busy = 1'b1;
            S_DONE:     begin o_done = 1'b1; o_busy = 1'b1; end
            S_ERR:      o_error = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift       <= '0;
            r_bit_in_byte <= '0;
            r_wait        <= '0;
            r_bits_sent   <= '0;
        end else begin
            if ((r_state == S_FETCH) && (w_next == S_SHIFT)) begin
                r_shift       <= i_byte_in;
                r_bit_in_byte <= '0;
            end else if (w_ack) begin
                r_shift       <= {r_shift[6:0], 1'b0};
                r_bit_in_byte <= r_bit_in_byte + 3'd1;
            end

            // wait counter restarts on every state change and on every accepted bit
            if ((r_state != w_next) || w_ack)
                r_wait <= '0;
            else if ((r_state == S_SHIFT) || (r_state == S_WAIT_END))
                r_wait <= r_wait + WAIT_W'(1);

            if (w_launch)
                r_bits_sent <= '0;
            else if (w_ack && (r_bits_sent != LAST_CNT))
                r_bits_sent <= r_bits_sent + CNT_W'(1);
        end
    end

    assign o_bits_sent = r_bits_sent;

endmodule

// File: tb/tb_rsnn_param_stream_tx.sv
// Randomized bench: a scripted host/receiver walks each transfer and states the
// expected outputs for every cycle; a negedge process compares them to the DUT.
module tb_rsnn_param_stream_tx;
    localparam int TOTAL_BITS  = 312;
    localparam int ACK_TIMEOUT = 63;
    localparam int CNT_W       = 9;
    localparam int NBYTES      = TOTAL_BITS / 8;

    localparam int M_NOM = 0, M_TMO = 1, M_EARLY = 2, M_RST = 3, M_SIMUL = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             i_start = 1'b0;
    logic [7:0]       i_byte_in = '0;
    logic             i_byte_valid = 1'b0;
    logic             o_byte_ready;
    logic             i_data_written = 1'b0;
    logic             i_end_writing = 1'b0;
    logic             o_load_params;
    logic             o_data_out;
    logic             o_busy;
    logic             o_done;
    logic             o_error;
    logic [CNT_W-1:0] o_bits_sent;

    always #5 clk = ~clk;

    rsnn_param_stream_tx #(
        .TOTAL_BITS(TOTAL_BITS), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_byte_in(i_byte_in),
        .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
        .i_data_written(i_data_written), .i_end_writing(i_end_writing),
        .o_load_params(o_load_params), .o_data_out(o_data_out), .o_busy(o_busy),
        .o_done(o_done), .o_error(o_error), .o_bits_sent(o_bits_sent)
    );

    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;
    logic e_busy = 0, e_load = 0, e_ready = 0, e_dout = 0, e_done = 0;
    logic m_err = 0;
    int   m_bits = 0;
    int   pend_bits = 0;
    int   load_cnt = 0, done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", o_busy, e_busy);
            chk("load_params", o_load_params, e_load);
            chk("byte_ready", o_byte_ready, e_ready);
            chk("data_out", o_data_out, e_dout);
            chk("done", o_done, e_done);
            chk("error", o_error, m_err);
            chk("bits_sent", o_bits_sent, m_bits);
            if (o_load_params === 1'b1) load_cnt++;
            if (o_done === 1'b1) done_cnt++;
        end
    end

    function automatic logic rnd();
        return ($urandom_range(0, 5) == 0);
    endfunction

    // start of a new cycle: clear pulse inputs, make the last ack visible in the count
    task automatic tick();
        @(posedge clk);
        #1;
        i_start = 1'b0; i_byte_valid = 1'b0; i_data_written = 1'b0;
        m_bits += pend_bits;
        pend_bits = 0;
    endtask

    task automatic set(input logic b, input logic l, input logic r, input logic d, input logic dn);
        e_busy = b; e_load = l; e_ready = r; e_dout = d; e_done = dn;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            tick(); set(0, 0, 0, 0, 0); i_data_written = rnd();
        end
    endtask

    task automatic xfer(input int mode, input int arg, input bit a5,
                        input int stall_by, input int stall_len, input int ack_dly);
        logic [7:0] img [NBYTES];
        logic [7:0] cap;
        cap = '0;
        for (int k = 0; k < NBYTES; k++) img[k] = a5 ? 8'hA5 : 8'($urandom);
        load_cnt = 0; done_cnt = 0;

        tick(); set(0, 0, 0, 0, 0); i_start = 1'b1;
        tick(); m_err = 0; m_bits = 0; set(1, 1, 0, 0, 0);

        for (int by = 0; by < NBYTES; by++) begin
            int g;
            g = (by == stall_by) ? stall_len : int'($urandom_range(0, 2));
            if (mode == M_EARLY && by * 8 == arg) begin
                tick(); set(1, 0, 1, 0, 0); i_end_writing = 1'b1;
                tick(); set(0, 0, 0, 0, 0); m_err = 1; i_end_writing = 1'b0;
                return;
            end
            for (int j = 0; j < g; j++) begin
                tick(); set(1, 0, 1, 0, 0); i_data_written = rnd(); i_start = rnd();
            end
            tick(); set(1, 0, 1, 0, 0); i_byte_in = img[by]; i_byte_valid = 1'b1;

            for (int k = 0; k < 8; k++) begin
                int   i;
                int   d;
                logic bt;
                i  = by * 8 + k;
                bt = img[by][7-k];
                if (mode == M_EARLY && i == arg) begin
                    tick(); set(1, 0, 0, bt, 0); i_end_writing = 1'b1;
                    tick(); set(0, 0, 0, 0, 0); m_err = 1; i_end_writing = 1'b0;
                    return;
                end
                if (mode == M_TMO && i == arg) begin
                    for (int j = 0; j < ACK_TIMEOUT; j++) begin
                        tick(); set(1, 0, 0, bt, 0);
                    end
                    tick(); set(0, 0, 0, 0, 0); m_err = 1;
                    return;
                end
                if (mode == M_RST && i == arg) begin
                    tick(); set(1, 0, 0, bt, 0);
                    #2;
                    reset = 1'b1;
                    set(0, 0, 0, 0, 0); m_bits = 0; m_err = 0;
                    #1;
                    chk("rst_async_bits", o_bits_sent, 0);
                    chk("rst_async_busy", o_busy, 0);
                    chk("rst_async_dout", o_data_out, 0);
                    tick(); tick();
                    reset = 1'b0;
                    return;
                end
                d = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
                for (int j = 0; j < d; j++) begin
                    tick(); set(1, 0, 0, bt, 0); i_start = rnd();
                end
                tick(); set(1, 0, 0, bt, 0); i_data_written = 1'b1; pend_bits = 1;
                if (by == 0) cap = {cap[6:0], o_data_out};
                if (mode == M_SIMUL && i == TOTAL_BITS - 1) i_end_writing = 1'b1;
            end
        end

        if (mode == M_SIMUL) begin
            tick(); set(1, 0, 0, 0, 1); i_end_writing = 1'b0;
        end else begin
            int e;
            e = $urandom_range(0, 3);
            for (int j = 0; j < e; j++) begin
                tick(); set(1, 0, 0, 0, 0); i_data_written = rnd();
            end
            tick(); set(1, 0, 0, 0, 0); i_end_writing = 1'b1;
            tick(); set(1, 0, 0, 0, 1); i_end_writing = 1'b0;
        end
        tick(); set(0, 0, 0, 0, 0);
        chk("load_pulses", load_cnt, 1);
        chk("done_pulses", done_cnt, 1);
        chk("bits_final", o_bits_sent, 312);
        if (a5) chk("first_byte", cap, 8'hA5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        chk_en = 1'b1;
        tick(); tick();
        reset = 1'b0;
        idle(3);

        xfer(M_NOM, 0, 1'b1, -1, 0, 2);
        xfer(M_NOM, 0, 1'b0, 5, 20, -1);

        xfer(M_TMO, 100, 1'b0, -1, 0, -1);
        chk("tmo_bits", o_bits_sent, 100);
        chk("tmo_err", o_error, 1);
        idle(4);
        xfer(M_NOM, 0, 1'b0, -1, 0, -1);

        xfer(M_EARLY, 200, 1'b0, -1, 0, -1);
        chk("early_bits", o_bits_sent, 200);
        chk("early_err", o_error, 1);
        idle(2);
        xfer(M_EARLY, 133, 1'b0, -1, 0, 1);
        chk("early_mid_bits", o_bits_sent, 133);

        xfer(M_RST, 57, 1'b0, -1, 0, -1);
        idle(2);
        xfer(M_NOM, 0, 1'b1, -1, 0, -1);

        xfer(M_SIMUL, 0, 1'b0, -1, 0, -1);
        chk("simul_err", o_error, 0);
        for (int n = 0; n < 3; n++) xfer(M_NOM, 0, 1'b0, int'($urandom_range(0, NBYTES - 1)), 5, -1);
        idle(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rsnn_param_stream_tx.md
Name: rsnn_param_stream_tx

Overview:
Transmitter end of the serial parameter-load interface of the RSNN chip. It accepts a 312-bit parameter image as a byte stream (39 bytes) and requests a load with load_params. It then shifts the image out one bit at a time on data_out (wired to the chip's data_in) and paces each bit on the receiver's data_written acknowledge. It completes on the receiver's end_writing. It sits in the harness/host-side controller that configures the RSNN weights (image bits 311:96) and neuron parameters (bits 95:0).

Parameters:
TOTAL_BITS, 312, number of serial bits per image; must be a multiple of 8
ACK_TIMEOUT, 63, max cycles to wait for data_written per bit before error
CNT_W, 9, width of bit counter (must hold TOTAL_BITS)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begin an image transfer
byte_in  input  8  next image byte; byte 0 = image bits 311:304
byte_valid  input  1  byte_in valid
byte_ready  output  1  transmitter accepts byte_in this cycle (valid&&ready = transfer)
data_written  input  1  receiver ack: current bit captured (1-cycle pulse)
end_writing  input  1  receiver level: full image written
load_params  output  1  load request to receiver's memory control unit
data_out  output  1  serial bit to receiver data_in
busy  output  1  transfer in progress
done  output  1  1-cycle pulse on successful completion
error  output  1  sticky until next start; timeout or protocol violation
bits_sent  output  CNT_W  acknowledged bit count

Behaviour:
- Reset (async): state IDLE; data_out=0, load_params=0, byte_ready=0, busy=0, done=0, error=0, bits_sent=0; shift reg and counters cleared. Reset mid-transfer aborts immediately, with no partial completion.
- States: IDLE, REQ, FETCH, SHIFT, WAIT_END, DONE, ERR.
- IDLE: start=1 -> REQ; clear error, bits_sent. start in any other state is ignored, except in ERR.
- REQ: load_params=1 for exactly one cycle -> FETCH.
- FETCH: byte_ready=1. On byte_valid -> load shift reg with byte_in, bit_in_byte=0 -> SHIFT. No timeout while waiting for bytes.
- SHIFT: data_out = shift_reg[7] (MSB first), stable from entry until ack. Wait counter increments each cycle.
  - On data_written: bits_sent+1, shift left, bit_in_byte+1, wait counter cleared.
  - After bit 7 of a byte: -> FETCH if bits_sent < TOTAL_BITS, else -> WAIT_END.
  - First bit of a new byte appears on data_out the cycle after the byte is accepted.
- Timeout: wait counter reaches ACK_TIMEOUT with no data_written -> ERR.
- WAIT_END: data_out=0. On end_writing=1 -> DONE. Timeout after ACK_TIMEOUT cycles -> ERR.
- DONE: done=1 one cycle -> IDLE.
- ERR: error=1 (held), busy=0, data_out=0. start -> REQ (retry, error cleared).
- Protocol violations -> ERR:
  - end_writing=1 while in SHIFT/FETCH with bits_sent < TOTAL_BITS.
  - end_writing already high in REQ.
- Stray acks: data_written outside SHIFT is ignored.
- busy=1 in REQ, FETCH, SHIFT, WAIT_END, DONE.
- Simultaneous data_written and end_writing in SHIFT on the final bit: count the bit, then go directly to DONE (skip WAIT_END).
- bits_sent saturates at TOTAL_BITS; never wraps.

Test Plan:
- Nominal: start, 39 bytes of 0xA5, receiver acks each bit 2 cycles after change, end_writing after bit 312 -> data_out sequence 1,0,1,0,0,1,0,1 repeated; load_params single pulse; bits_sent=312; done pulse; busy falls.
- Byte stall: byte_valid withheld 20 cycles between byte 4 and 5 -> byte_ready held high, no error, data_out stays 0-frozen, transfer completes.
- Ack timeout: receiver stops acking after bit 100 -> error=1 exactly ACK_TIMEOUT cycles after bit 100 driven; bits_sent=100; start retry completes with error=0.
- Early end_writing asserted after bit 200 -> ERR, error=1, bits_sent=200.
- Reset asserted mid-byte at bit 57 -> all outputs 0 same cycle; new start after release transfers full image from byte 0.
- Final-bit simultaneity: data_written and end_writing together on bit 312 -> done next cycle, no error; start during busy ignored.
